// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle SHR/MUL sequencer driving a combinational ALU (optional MUL via SEQ_MUL_EN)
module alu_seq_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_kind,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_n,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_rslt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0]   OP_NOP = 3'b000;
  localparam logic [2:0]   OP_SHR = 3'b001;
  localparam logic [2:0]   OP_ADD = 3'b010;
  localparam logic [W-1:0] W_CNT  = W'(W);
  localparam logic [W-1:0] ONE    = W'(1);

  state_t       state;
  state_t       next_state;
  logic [W-1:0] acc;
  logic [W-1:0] cnt;

  logic [W-1:0] shr_cnt;
  logic [W-1:0] load_cnt;
  logic [W-1:0] load_acc;
  logic         load_err;

`ifdef SEQ_MUL_EN
  logic         kind;
  logic [W-1:0] addend;
`endif

  // Request decode: initial count, accumulator seed and error flag for an accept.
  always_comb begin
    shr_cnt  = (req_n > W_CNT) ? W_CNT : req_n;
    load_cnt = shr_cnt;
    load_acc = req_a;
    load_err = 1'b0;
    if (req_kind) begin
`ifdef SEQ_MUL_EN
      load_cnt = req_n;
      load_acc = '0;
      load_err = 1'b0;
`else
      // MUL unsupported: skip straight to an error response with zero data.
      load_cnt = '0;
      load_acc = '0;
      load_err = 1'b1;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and output decode; ALU is driven only while in RUN.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_op     = OP_NOP;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = (load_cnt == '0) ? RESP : RUN;
      end
      RUN: begin
        alu_a  = acc;
        alu_op = OP_SHR;
`ifdef SEQ_MUL_EN
        if (kind) begin
          alu_op = OP_ADD;
          alu_b  = addend;
        end
`endif
        if (cnt == ONE) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load on accept, fold ALU result back each RUN cycle, capture response.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
`ifdef SEQ_MUL_EN
      kind     <= 1'b0;
      addend   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc     <= load_acc;
            cnt     <= load_cnt;
            rsp_err <= load_err;
            if (load_cnt == '0) rsp_data <= load_acc;
`ifdef SEQ_MUL_EN
            kind    <= req_kind;
            addend  <= req_a;
`endif
          end
        end
        RUN: begin
          acc <= alu_rslt;
          cnt <= cnt - ONE;
          if (cnt == ONE) rsp_data <= alu_rslt;
        end
        default: begin
        end
      endcase
    end
  end

  // ALU OP_ADD is referenced only when MUL is built in.
  logic unused_op;
  assign unused_op = ^OP_ADD;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_kind;
  logic [W-1:0] req_a;
  logic [W-1:0] req_n;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_rslt;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;

  int total = 0;
  int bad   = 0;

  // results of the last run_req
  int           r_ops;
  int           r_other_ops;
  int           r_cycle;
  logic [W-1:0] r_data;
  logic         r_err;

  always #5 clk = ~clk;

  // ALU model: 001 = shift right by one, 010 = add, else 0
  assign alu_rslt = (alu_op == 3'b001) ? (alu_a >> 1) :
                    (alu_op == 3'b010) ? (alu_a + alu_b) : '0;

  alu_seq_ctrl #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_a(req_a), .req_n(req_n),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_rslt(alu_rslt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Issue one request (caller is at a negedge in IDLE) and watch it to its response.
  task automatic run_req(input logic kind, input logic [W-1:0] a, input logic [W-1:0] n,
                         input logic [2:0] op);
    int cyc;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_kind = kind; req_a = a; req_n = n;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    r_ops = 0; r_other_ops = 0; r_cycle = -1; r_data = 'x; r_err = 1'bx;
    for (cyc = 1; cyc < 300; cyc++) begin
      if (rsp_valid) begin
        r_cycle = cyc; r_data = rsp_data; r_err = rsp_err;
        break;
      end
      if (alu_op === op) r_ops++;
      else if (alu_op !== 3'b000) r_other_ops++;
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_kind = 1'b0; req_a = '0; req_n = '0; rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({req_ready, rsp_valid, alu_op, alu_a, alu_b, rsp_data, rsp_err} !== {1'b1, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b vld=%b op=%b a=%h b=%h d=%h e=%b want 1 0 000 00 00 00 0",
               req_ready, rsp_valid, alu_op, alu_a, alu_b, rsp_data, rsp_err);
    end
  endtask

  task automatic test_shr;
    run_req(1'b0, 8'hB4, 8'd3, 3'b001);
    total++;
    if (r_ops !== 3 || r_other_ops !== 0) begin
      bad++; $display("FAIL shr_ops got %0d (other %0d) want 3", r_ops, r_other_ops);
    end
    total++;
    if (r_cycle !== 4 || r_data !== 8'h16 || r_err !== 1'b0) begin
      bad++; $display("FAIL shr_rsp got cyc=%0d d=%h e=%b want cyc=4 d=16 e=0", r_cycle, r_data, r_err);
    end
  endtask

  task automatic test_shr_boundaries;
    run_req(1'b0, 8'h5A, 8'd0, 3'b001);
    total++;
    if (r_cycle !== 1 || r_data !== 8'h5A || r_ops !== 0 || r_err !== 1'b0) begin
      bad++; $display("FAIL shr_n0 got cyc=%0d d=%h ops=%0d e=%b want cyc=1 d=5a ops=0 e=0", r_cycle, r_data, r_ops, r_err);
    end
    run_req(1'b0, 8'hFF, 8'd200, 3'b001);
    total++;
    if (r_ops !== 8 || r_cycle !== 9 || r_data !== 8'h00) begin
      bad++; $display("FAIL shr_clamp got ops=%0d cyc=%0d d=%h want ops=8 cyc=9 d=00", r_ops, r_cycle, r_data);
    end
    run_req(1'b0, 8'h81, 8'd7, 3'b001);
    total++;
    if (r_ops !== 7 || r_cycle !== 8 || r_data !== 8'h01) begin
      bad++; $display("FAIL shr_n7 got ops=%0d cyc=%0d d=%h want ops=7 cyc=8 d=01", r_ops, r_cycle, r_data);
    end
  endtask

  task automatic test_mul;
`ifdef SEQ_MUL_EN
    run_req(1'b1, 8'd13, 8'd11, 3'b010);
    total++;
    if (r_ops !== 11 || r_other_ops !== 0 || r_cycle !== 12 || r_data !== 8'h8F || r_err !== 1'b0) begin
      bad++; $display("FAIL mul_13x11 got ops=%0d cyc=%0d d=%h e=%b want ops=11 cyc=12 d=8f e=0", r_ops, r_cycle, r_data, r_err);
    end
    run_req(1'b1, 8'h40, 8'd5, 3'b010);
    total++;
    if (r_data !== 8'h40 || r_cycle !== 6 || r_err !== 1'b0) begin
      bad++; $display("FAIL mul_wrap got cyc=%0d d=%h e=%b want cyc=6 d=40 e=0", r_cycle, r_data, r_err);
    end
    run_req(1'b1, 8'd9, 8'd0, 3'b010);
    total++;
    if (r_data !== 8'h00 || r_cycle !== 1 || r_ops !== 0) begin
      bad++; $display("FAIL mul_n0 got cyc=%0d d=%h ops=%0d want cyc=1 d=00 ops=0", r_cycle, r_data, r_ops);
    end
`else
    run_req(1'b1, 8'd13, 8'd11, 3'b010);
    total++;
    if (r_cycle !== 1 || r_data !== 8'h00 || r_err !== 1'b1 || r_ops !== 0 || r_other_ops !== 0) begin
      bad++; $display("FAIL mul_disabled got cyc=%0d d=%h e=%b ops=%0d/%0d want cyc=1 d=00 e=1 ops=0/0",
                      r_cycle, r_data, r_err, r_ops, r_other_ops);
    end
    run_req(1'b1, 8'h40, 8'd5, 3'b010);
    total++;
    if (r_cycle !== 1 || r_err !== 1'b1 || r_data !== 8'h00) begin
      bad++; $display("FAIL mul_disabled2 got cyc=%0d d=%h e=%b want cyc=1 d=00 e=1", r_cycle, r_data, r_err);
    end
`endif
    // rsp_err must clear again for a following SHR
    run_req(1'b0, 8'h10, 8'd1, 3'b001);
    total++;
    if (r_err !== 1'b0 || r_data !== 8'h08 || r_cycle !== 2) begin
      bad++; $display("FAIL shr_after_mul got cyc=%0d d=%h e=%b want cyc=2 d=08 e=0", r_cycle, r_data, r_err);
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_kind = 1'b0; req_a = 8'h5A; req_n = 8'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || req_ready !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d got vld=%b d=%h rdy=%b want 1 5a 0", i, rsp_valid, rsp_data, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    // release cycle: new request presented at the same time must not be taken
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_kind = 1'b0; req_a = 8'h80; req_n = 8'd1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_op !== 3'b000) begin
      bad++; $display("FAIL release_not_accepted got rdy=%b vld=%b op=%b want 1 0 000", req_ready, rsp_valid, alu_op);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (alu_op !== 3'b001 || alu_a !== 8'h80 || req_ready !== 1'b0) begin
      bad++; $display("FAIL next_accept got op=%b a=%h rdy=%b want 001 80 0", alu_op, alu_a, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h40) begin
      bad++; $display("FAIL next_rsp got vld=%b d=%h want 1 40", rsp_valid, rsp_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int seen;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_kind = 1'b0; req_a = 8'hF0; req_n = 8'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (alu_op !== 3'b001 || alu_a !== 8'h78) begin
      bad++; $display("FAIL run_cycle2 got op=%b a=%h want 001 78", alu_op, alu_a);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_op !== 3'b000) begin
      bad++; $display("FAIL reset_mid_run got rdy=%b vld=%b op=%b want 1 0 000", req_ready, rsp_valid, alu_op);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid === 1'b1 || alu_op !== 3'b000) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL abandoned_rsp got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_shr;
    test_shr_boundaries;
    test_mul;
    test_backpressure;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer for the single-cycle `alu`. It accepts one iterative request at a time, either an N-bit logical shift right or a repeated-add multiply. It drives the ALU's `ALUOp`/`inA`/`inB` once per cycle and feeds `rslt` back into an internal accumulator. When the count expires, it returns the accumulated result over a valid/ready response port.

## Interface
- `W`, default 8: datapath width; must match the ALU width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset; takes priority over all inputs.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_kind` in 1: 0 = SHR, 1 = MUL.
- `req_a` in W: operand (shift source or multiplicand).
- `req_n` in W: shift count or multiplier, unsigned.
- `alu_op` out 3: to ALU `ALUOp`.
- `alu_a` out W: to ALU `inA`.
- `alu_b` out W: to ALU `inB`.
- `alu_rslt` in W: from ALU `rslt`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out W: result.
- `rsp_err` out 1: request kind unsupported; qualified by `rsp_valid`.

## Operation
- **States:** IDLE, RUN, RESP.
- **Reset:** state = IDLE; `acc`, `addend`, `cnt`, `rsp_data`, `rsp_err` = 0.
- **Reset output values:** `req_ready` = 1, `rsp_valid` = 0, `alu_op` = 3'b000, `alu_a` = 0, `alu_b` = 0.
- **IDLE:**
  - Accept when `req_valid & req_ready`.
  - SHR: `acc` = `req_a`; `cnt` = min(`req_n`, W).
  - MUL: `acc` = 0; `addend` = `req_a`; `cnt` = `req_n`.
  - `cnt` == 0 → RESP. Otherwise → RUN.
- **RUN, one ALU pass per cycle:**
  - SHR drives `alu_op` = 3'b001, `alu_a` = `acc`, `alu_b` = 0.
  - MUL drives `alu_op` = 3'b010, `alu_a` = `acc`, `alu_b` = `addend`.
  - Each edge: `acc` ← `alu_rslt`; `cnt` ← `cnt` − 1.
  - When `cnt` == 1 at the edge → RESP.
- **RESP:**
  - `rsp_valid` = 1; `rsp_data` = `acc`.
  - `rsp_data` and `rsp_err` are held stable until `rsp_ready`, then → IDLE.
- **Outside RUN:** `alu_op` = 3'b000, `alu_a` = `alu_b` = 0. The ALU `taken` output is unused.
- **Arithmetic:** all arithmetic is modulo 2^W. SHR is zero-fill. A MUL product overflowing W bits wraps silently.
- **Simultaneous events:** `req_valid` during RESP, even with `rsp_ready` high, is not accepted. The earliest next accept is the following cycle in IDLE.
- **Reset mid-RUN or mid-RESP:** the operation is abandoned with no response. State is IDLE in the next cycle.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..n, where n is the effective `cnt`. `rsp_valid` rises in cycle n+1.
- n = 0: `rsp_valid` in cycle 1, with no ALU pass.
- The ALU is combinational, so each RUN cycle sees `alu_rslt` in the same cycle. There is no ALU pipeline stage.
- Maximum throughput: one request per n+2 cycles when `rsp_ready` is held high.
- All outputs except `req_ready` come from registered state. `req_ready` = (state == IDLE), decoded combinationally from the state register.

## Configuration
- **`SEQ_MUL_EN` defined:** MUL is supported as described above.
- **`SEQ_MUL_EN` undefined:**
  - The `addend` register and MUL path are removed.
  - A request with `req_kind` = 1 is still accepted and goes directly to RESP.
  - The response carries `rsp_data` = 0 and `rsp_err` = 1, and appears in cycle 1.
  - SHR behaviour is unchanged.
- **`rsp_err`** is always 0 for SHR, and always 0 when `SEQ_MUL_EN` is defined.

## Test plan
- SHR, `req_a` = 0xB4, `req_n` = 3 → `alu_op` = 001 in cycles 1–3; `rsp_valid` in cycle 4 with `rsp_data` = 0x16, `rsp_err` = 0.
- MUL, `req_a` = 13, `req_n` = 11, with `SEQ_MUL_EN` → `alu_op` = 010 for 11 cycles; `rsp_data` = 0x8F in cycle 12.
- MUL, `req_a` = 13, `req_n` = 11, without `SEQ_MUL_EN` → `rsp_err` = 1, `rsp_data` = 0x00 in cycle 1; `alu_op` stays 000.
- MUL wrap, `req_a` = 0x40, `req_n` = 5 → `rsp_data` = 0x40 (320 mod 256).
- Count boundaries:
  - SHR, `req_a` = 0x5A, `req_n` = 0 → `rsp_data` = 0x5A in cycle 1; no 001 op issued.
  - SHR, `req_a` = 0xFF, `req_n` = 200 → clamped to 8 passes; `rsp_data` = 0x00 in cycle 9.
- Handshake and reset:
  - Hold `rsp_ready` = 0 for 3 cycles in RESP → `rsp_data` stable and `req_ready` = 0 throughout. A `req_valid` pulse in the release cycle is not accepted; it is accepted in the next cycle.
  - Assert `reset` in RUN cycle 2 of a 5-pass SHR → next cycle IDLE, `req_ready` = 1, `rsp_valid` = 0, `alu_op` = 000, and no response is ever emitted.
